// File: rtl/down_timer.sv
// down_timer: loadable, prescaled down-counter.
// Counts a programmed value to zero, pulses `expired` for one cycle and sets a
// sticky `irq` flag on expiry. Periodic mode reloads and keeps running;
// one-shot mode parks in DONE until the next load.
module down_timer #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  periodic,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  irq_clr,
    output logic [WIDTH-1:0]      count,
    output logic                  running,
    output logic                  done,
    output logic                  expired,
    output logic                  irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]      CNT_ONE = WIDTH'(1);
    localparam logic [PRESCALE_W-1:0] PSC_ONE = PRESCALE_W'(1);

    state_t                  state_q;
    logic [WIDTH-1:0]        count_q;
    logic [WIDTH-1:0]        reload_q;
    logic [PRESCALE_W-1:0]   presc_q;
    logic                    expired_q;
    logic                    irq_q;
    logic                    tick_d;

    // Decrement strobe; >= keeps ticking promptly if prescale is lowered mid-count.
    always_comb begin
        tick_d = (state_q == RUN) && (presc_q >= prescale);
    end

    // Control FSM, prescaler, count and flags; priority rst > load > stop > start > tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            presc_q   <= '0;
            expired_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            expired_q <= 1'b0;
            // A same-cycle expiry below overrides this clear.
            if (irq_clr) begin
                irq_q <= 1'b0;
            end

            if (load) begin
                count_q  <= load_val;
                reload_q <= load_val;
                presc_q  <= '0;
                if (state_q == DONE) begin
                    state_q <= IDLE;
                end else if ((state_q == RUN) && (load_val == '0)) begin
                    state_q <= IDLE;
                end
            end else if (stop) begin
                if (state_q == RUN) begin
                    state_q <= IDLE;
                    presc_q <= '0;
                end
            end else if (start && (state_q == IDLE) && (count_q != '0)) begin
                state_q <= RUN;
            end else if (state_q == RUN) begin
                if (tick_d) begin
                    presc_q <= '0;
                    if (count_q > CNT_ONE) begin
                        count_q <= count_q - CNT_ONE;
                    end else if (count_q == CNT_ONE) begin
                        expired_q <= 1'b1;
                        irq_q     <= 1'b1;
                        if (periodic) begin
                            count_q <= reload_q;
                        end else begin
                            count_q <= '0;
                            state_q <= DONE;
                        end
                    end
                end else begin
                    presc_q <= presc_q + PSC_ONE;
                end
            end
        end
    end

    assign count   = count_q;
    assign running = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign expired = expired_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: directed stimulus against a cycle model of the timer, with
// hand-computed expectations at key points of each scenario.
module tb_down_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic       start = 1'b1;
    logic       stop = 1'b0;
    logic       periodic = 1'b0;
    logic [3:0] prescale = 4'd0;
    logic       irq_clr = 1'b0;
    logic [7:0] count;
    logic       running, done, expired, irq;

    int checks = 0;
    int errors = 0;

    down_timer #(.WIDTH(8), .PRESCALE_W(4)) dut (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val),
        .start(start), .stop(stop), .periodic(periodic),
        .prescale(prescale), .irq_clr(irq_clr),
        .count(count), .running(running), .done(done),
        .expired(expired), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: mode 0=idle, 1=counting, 2=finished.
    int m_cnt = 0, m_rel = 0, m_pc = 0, m_mode = 0;
    int m_exp = 0, m_irq = 0;
    bit armed = 1'b0;

    always @(posedge clk) begin
        armed = 1'b1;
        if (rst) begin
            m_cnt = 0; m_rel = 0; m_pc = 0; m_mode = 0; m_exp = 0; m_irq = 0;
        end else begin
            m_exp = 0;
            if (irq_clr) m_irq = 0;
            if (load) begin
                m_cnt = int'(load_val);
                m_rel = m_cnt;
                m_pc  = 0;
                m_mode = (m_mode == 1 && m_cnt != 0) ? 1 : 0;
            end else if (stop) begin
                if (m_mode == 1) begin m_mode = 0; m_pc = 0; end
            end else if (start && m_mode == 0 && m_cnt > 0) begin
                m_mode = 1;
            end else if (m_mode == 1) begin
                if (m_pc < int'(prescale)) begin
                    m_pc = m_pc + 1;
                end else begin
                    m_pc = 0;
                    if (m_cnt == 1) begin
                        m_exp = 1;
                        m_irq = 1;
                        m_cnt = periodic ? m_rel : 0;
                        m_mode = periodic ? 1 : 2;
                    end else if (m_cnt > 1) begin
                        m_cnt = m_cnt - 1;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (armed) begin
            chk("cyc_count",   int'(count), m_cnt);
            chk("cyc_running", int'(running), (m_mode == 1) ? 1 : 0);
            chk("cyc_done",    int'(done), (m_mode == 2) ? 1 : 0);
            chk("cyc_expired", int'(expired), m_exp);
            chk("cyc_irq",     int'(irq), m_irq);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    int seq[8] = '{3, 2, 1, 4, 3, 2, 1, 4};

    initial begin
        // Reset held three edges with start asserted.
        step(3);
        chk("rst_count", int'(count), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_expired", int'(expired), 0);
        chk("rst_irq", int'(irq), 0);
        rst = 1'b0; start = 1'b0;

        // Load of zero while running drops to idle without expiry.
        load = 1'b1; load_val = 8'd3; step(1); load = 1'b0;
        start = 1'b1; step(1); start = 1'b0;
        chk("ld0_pre_running", int'(running), 1);
        load = 1'b1; load_val = 8'd0; step(1); load = 1'b0;
        chk("ld0_running", int'(running), 0);
        chk("ld0_count", int'(count), 0);
        chk("ld0_expired", int'(expired), 0);

        // One-shot, prescale 0.
        load = 1'b1; load_val = 8'd5; step(1); load = 1'b0;
        start = 1'b1; step(1); start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step(1);
            chk("os_count", int'(count), 5 - i);
            chk("os_expired", int'(expired), (i == 5) ? 1 : 0);
        end
        chk("os_done", int'(done), 1);
        chk("os_running", int'(running), 0);
        chk("os_irq", int'(irq), 1);
        step(1);
        chk("os_expired_gone", int'(expired), 0);
        irq_clr = 1'b1; step(1); irq_clr = 1'b0;
        chk("os_irq_clr", int'(irq), 0);
        start = 1'b1; step(1); start = 1'b0;
        chk("os_restart_done", int'(done), 1);
        chk("os_restart_running", int'(running), 0);

        // Prescale 2: one step every 3 cycles, expiry after edge 9.
        prescale = 4'd2;
        load = 1'b1; load_val = 8'd3; step(1); load = 1'b0;
        chk("ps_idle_done", int'(done), 0);
        start = 1'b1; step(1); start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step(1);
            chk("ps_count", int'(count), 3 - k / 3);
            chk("ps_expired", int'(expired), (k == 9) ? 1 : 0);
        end
        prescale = 4'd0;

        // Periodic reload of 4.
        periodic = 1'b1;
        load = 1'b1; load_val = 8'd4; step(1); load = 1'b0;
        start = 1'b1; step(1); start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("per_count", int'(count), seq[i]);
            chk("per_expired", int'(expired), (i % 4 == 3) ? 1 : 0);
            chk("per_running", int'(running), 1);
            chk("per_irq", int'(irq), 1);
        end
        step(3);
        irq_clr = 1'b1; step(1); irq_clr = 1'b0;
        chk("clr_exp_count", int'(count), 4);
        chk("clr_exp_expired", int'(expired), 1);
        chk("clr_exp_irq", int'(irq), 1);
        irq_clr = 1'b1; step(1); irq_clr = 1'b0;
        chk("clr_irq", int'(irq), 0);
        chk("clr_count", int'(count), 3);
        step(2);
        chk("pre_coll_count", int'(count), 1);
        load = 1'b1; load_val = 8'd7; step(1); load = 1'b0;
        chk("coll_count", int'(count), 7);
        chk("coll_expired", int'(expired), 0);
        chk("coll_irq", int'(irq), 0);
        chk("coll_running", int'(running), 1);

        // Stop/resume, including stop colliding with a tick.
        periodic = 1'b0;
        load = 1'b1; load_val = 8'd10; step(1); load = 1'b0;
        chk("sr_load_count", int'(count), 10);
        chk("sr_load_running", int'(running), 1);
        step(4);
        chk("sr_pre_stop", int'(count), 6);
        stop = 1'b1; step(1); stop = 1'b0;
        chk("sr_stop_count", int'(count), 6);
        chk("sr_stop_running", int'(running), 0);
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("sr_frozen", int'(count), 6);
        end
        start = 1'b1; step(1); start = 1'b0;
        chk("sr_start_count", int'(count), 6);
        chk("sr_start_running", int'(running), 1);
        step(1);
        chk("sr_resume1", int'(count), 5);
        step(1);
        chk("sr_resume2", int'(count), 4);

        // Reset mid-run.
        rst = 1'b1; step(1); rst = 1'b0;
        chk("mrst_count", int'(count), 0);
        chk("mrst_running", int'(running), 0);
        chk("mrst_done", int'(done), 0);
        chk("mrst_expired", int'(expired), 0);
        chk("mrst_irq", int'(irq), 0);
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
